// File: rtl/bp_me_bank_dispatch_pkg.sv
// Shared types for the multi-bank memory dispatch path: processor configs, the BedRock mem header,
// dispatch FSM states, and the bank-select function reused by the L2 address-strip logic.
package bp_me_bank_dispatch_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg    = 2'd0,
        e_bp_unicore_l2_cfg = 2'd1,
        e_bp_wide_paddr_cfg = 2'd2
    } bp_params_e;

    // The header address field is sized for the widest config; narrower configs leave the top bits zero.
    localparam int paddr_width_gp    = 56;
    localparam int lce_id_width_gp   = 8;
    localparam int lce_assoc_gp      = 8;
    localparam int bank_sel_width_gp = 4;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'b0000,
        e_bedrock_mem_wr    = 4'b0001,
        e_bedrock_mem_uc_rd = 4'b0010,
        e_bedrock_mem_uc_wr = 4'b0011,
        e_bedrock_mem_pre   = 4'b0100,
        e_bedrock_mem_amo   = 4'b0101
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'b000,
        e_bedrock_msg_size_2   = 3'b001,
        e_bedrock_msg_size_4   = 3'b010,
        e_bedrock_msg_size_8   = 3'b011,
        e_bedrock_msg_size_16  = 3'b100,
        e_bedrock_msg_size_32  = 3'b101,
        e_bedrock_msg_size_64  = 3'b110,
        e_bedrock_msg_size_128 = 3'b111
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [lce_id_width_gp-1:0]       lce_id;
        logic [$clog2(lce_assoc_gp)-1:0]  way_id;
    } bp_bedrock_mem_payload_s;

    typedef struct packed {
        bp_bedrock_mem_type_e     msg_type;
        logic [3:0]               subop;
        logic [paddr_width_gp-1:0] addr;
        bp_bedrock_msg_size_e     size;
        bp_bedrock_mem_payload_s  payload;
    } bp_bedrock_mem_header_s;

    typedef enum logic {
        e_cmd_idle   = 1'b0,
        e_cmd_stream = 1'b1
    } bp_me_dispatch_state_e;

    function automatic int bp_cfg_paddr_width(input bp_params_e cfg);
        case (cfg)
            e_bp_wide_paddr_cfg: return paddr_width_gp;
            default:             return 40;
        endcase
    endfunction

    // Bank index from the field at offset; the hash folds in the next field of equal width.
    function automatic logic [bank_sel_width_gp-1:0] bp_me_bank_sel(
        input logic [paddr_width_gp-1:0] addr,
        input int                        offset,
        input int                        lg_banks,
        input bit                        hash
    );
        logic [bank_sel_width_gp-1:0] sel;
        sel = '0;
        for (int i = 0; i < bank_sel_width_gp; i++) begin
            if (i < lg_banks && offset + i < paddr_width_gp) begin
                sel[i] = addr[offset + i];
                if (hash && offset + lg_banks + i < paddr_width_gp) begin
                    sel[i] = sel[i] ^ addr[offset + lg_banks + i];
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/bp_me_bank_order_fifo.sv
// Small 1r1w FIFO recording which bank owns each outstanding request; depth need not be a power of two.
module bp_me_bank_order_fifo
    import bp_me_bank_dispatch_pkg::*;
#(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [width_p-1:0]           data_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [width_p-1:0]           head_o,
    output logic [$clog2(els_p+1)-1:0]   count_o
);

    localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int count_width_lp = $clog2(els_p + 1);

    logic [width_p-1:0]        mem_r [els_p];
    logic [ptr_width_lp-1:0]   rd_ptr_r, wr_ptr_r;
    logic [count_width_lp-1:0] count_r;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] ptr);
        return (ptr == ptr_width_lp'(els_p - 1)) ? '0 : ptr + ptr_width_lp'(1);
    endfunction

    // NOTE: storage is not reset; an entry is only ever read after it has been written.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_i) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (pop_i)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({push_i, pop_i})
                2'b10:   count_r <= count_r + count_width_lp'(1);
                2'b01:   count_r <= count_r - count_width_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign full_o  = (count_r == count_width_lp'(els_p));
    assign empty_o = (count_r == '0);
    assign head_o  = mem_r[rd_ptr_r];
    assign count_o = count_r;

endmodule

// File: rtl/bp_me_bank_dispatch.sv
// Splits the core's memory command stream across L2 banks by address and merges bank responses
// back to the core in request order.
module bp_me_bank_dispatch
    import bp_me_bank_dispatch_pkg::*;
#(
    parameter bp_params_e bp_params_p       = e_bp_default_cfg,
    parameter int         data_width_p      = 64,
    parameter int         num_banks_p       = 2,
    parameter int         bank_offset_p     = 6,
    parameter int         hash_en_p         = 0,
    parameter int         max_outstanding_p = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,

    input  bp_bedrock_mem_header_s                 mem_cmd_header_i,
    input  logic [data_width_p-1:0]                mem_cmd_data_i,
    input  logic                                   mem_cmd_v_i,
    output logic                                   mem_cmd_ready_and_o,
    input  logic                                   mem_cmd_last_i,

    output bp_bedrock_mem_header_s                 mem_resp_header_o,
    output logic [data_width_p-1:0]                mem_resp_data_o,
    output logic                                   mem_resp_v_o,
    input  logic                                   mem_resp_ready_and_i,
    output logic                                   mem_resp_last_o,

    output bp_bedrock_mem_header_s [num_banks_p-1:0]    bank_cmd_header_o,
    output logic [num_banks_p-1:0][data_width_p-1:0]    bank_cmd_data_o,
    output logic [num_banks_p-1:0]                      bank_cmd_v_o,
    input  logic [num_banks_p-1:0]                      bank_cmd_ready_and_i,
    output logic [num_banks_p-1:0]                      bank_cmd_last_o,

    input  bp_bedrock_mem_header_s [num_banks_p-1:0]    bank_resp_header_i,
    input  logic [num_banks_p-1:0][data_width_p-1:0]    bank_resp_data_i,
    input  logic [num_banks_p-1:0]                      bank_resp_v_i,
    output logic [num_banks_p-1:0]                      bank_resp_yumi_o,
    input  logic [num_banks_p-1:0]                      bank_resp_last_i,

    output logic [$clog2(max_outstanding_p+1)-1:0]      outstanding_o
);

    localparam int lg_banks_lp    = $clog2(num_banks_p);
    localparam int sel_width_lp   = (lg_banks_lp == 0) ? 1 : lg_banks_lp;
    localparam int paddr_width_lp = bp_cfg_paddr_width(bp_params_p);
    localparam logic [paddr_width_gp-1:0] addr_mask_lp =
        {paddr_width_gp{1'b1}} >> (paddr_width_gp - paddr_width_lp);

    bp_me_dispatch_state_e     state_r;
    logic [sel_width_lp-1:0]   cmd_bank_r;
    logic [sel_width_lp-1:0]   sel, route_bank, head;
    logic [paddr_width_gp-1:0] cmd_addr;
    logic                      idle, cmd_open, cmd_fire, push, pop;
    logic                      fifo_full, fifo_empty, resp_fire;

    assign cmd_addr = mem_cmd_header_i.addr & addr_mask_lp;
    assign sel      = sel_width_lp'(bp_me_bank_sel(cmd_addr, bank_offset_p, lg_banks_lp, hash_en_p != 0));

    assign idle       = (state_r == e_cmd_idle);
    assign route_bank = idle ? sel : cmd_bank_r;

    // A full order FIFO blocks only first beats; reset forces every handshake output low at once.
    assign cmd_open            = reset_n_i & (~idle | ~fifo_full);
    assign mem_cmd_ready_and_o = cmd_open & bank_cmd_ready_and_i[route_bank];
    assign cmd_fire            = mem_cmd_v_i & mem_cmd_ready_and_o;
    assign push                = idle & cmd_fire;

    always_comb begin
        // NOTE: defaults first so the indexed assignments below cannot infer latches.
        bank_cmd_v_o = '0;
        for (int b = 0; b < num_banks_p; b++) begin
            bank_cmd_header_o[b] = mem_cmd_header_i;
            bank_cmd_data_o[b]   = mem_cmd_data_i;
        end
        bank_cmd_v_o[route_bank] = mem_cmd_v_i & cmd_open;
    end

    assign bank_cmd_last_o = {num_banks_p{mem_cmd_last_i & reset_n_i}};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= e_cmd_idle;
            cmd_bank_r <= '0;
        end else begin
            case (state_r)
                e_cmd_idle: begin
                    if (cmd_fire && !mem_cmd_last_i) begin
                        state_r    <= e_cmd_stream;
                        cmd_bank_r <= sel;
                    end
                end
                e_cmd_stream: begin
                    if (cmd_fire && mem_cmd_last_i) begin
                        state_r <= e_cmd_idle;
                    end
                end
                default: state_r <= e_cmd_idle;
            endcase
        end
    end

    // Only the bank at the FIFO head may present a response; the others wait untouched.
    assign mem_resp_v_o      = ~fifo_empty & bank_resp_v_i[head];
    assign mem_resp_header_o = bank_resp_header_i[head];
    assign mem_resp_data_o   = bank_resp_data_i[head];
    assign mem_resp_last_o   = mem_resp_v_o & bank_resp_last_i[head];
    assign resp_fire         = mem_resp_v_o & mem_resp_ready_and_i;
    assign pop               = resp_fire & bank_resp_last_i[head];

    always_comb begin
        bank_resp_yumi_o       = '0;
        bank_resp_yumi_o[head] = resp_fire;
    end

    bp_me_bank_order_fifo #(
        .width_p (sel_width_lp),
        .els_p   (max_outstanding_p)
    ) order_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (sel),
        .push_i    (push),
        .pop_i     (pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (head),
        .count_o   (outstanding_o)
    );

endmodule

// File: tb/tb_bp_me_bank_dispatch.sv
// Directed bench: a 4-bank direct-select instance and a 2-bank hashed instance with a 2-deep order FIFO.
`timescale 1ns/1ps
module tb_bp_me_bank_dispatch;
    import bp_me_bank_dispatch_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    // Instance A: 4 banks, direct select, depth 4
    bp_bedrock_mem_header_s             a_cmd_hdr, a_resp_hdr;
    logic [63:0]                        a_cmd_data, a_resp_data;
    logic                               a_cmd_v, a_cmd_ready, a_cmd_last;
    logic                               a_resp_v, a_resp_ready, a_resp_last;
    bp_bedrock_mem_header_s [3:0]       a_bcmd_hdr, a_bresp_hdr;
    logic [3:0][63:0]                   a_bcmd_data, a_bresp_data;
    logic [3:0]                         a_bcmd_v, a_bcmd_ready, a_bcmd_last;
    logic [3:0]                         a_bresp_v, a_bresp_yumi, a_bresp_last;
    logic [2:0]                         a_outst;

    // Instance B: 2 banks, hashed select, depth 2
    bp_bedrock_mem_header_s             b_cmd_hdr, b_resp_hdr;
    logic [63:0]                        b_cmd_data, b_resp_data;
    logic                               b_cmd_v, b_cmd_ready, b_cmd_last;
    logic                               b_resp_v, b_resp_ready, b_resp_last;
    bp_bedrock_mem_header_s [1:0]       b_bcmd_hdr, b_bresp_hdr;
    logic [1:0][63:0]                   b_bcmd_data, b_bresp_data;
    logic [1:0]                         b_bcmd_v, b_bcmd_ready, b_bcmd_last;
    logic [1:0]                         b_bresp_v, b_bresp_yumi, b_bresp_last;
    logic [1:0]                         b_outst;

    bp_me_bank_dispatch #(
        .bp_params_p(e_bp_default_cfg), .data_width_p(64), .num_banks_p(4),
        .bank_offset_p(6), .hash_en_p(0), .max_outstanding_p(4)
    ) dut_a (
        .clk_i(clk), .reset_n_i(rst_n),
        .mem_cmd_header_i(a_cmd_hdr), .mem_cmd_data_i(a_cmd_data), .mem_cmd_v_i(a_cmd_v),
        .mem_cmd_ready_and_o(a_cmd_ready), .mem_cmd_last_i(a_cmd_last),
        .mem_resp_header_o(a_resp_hdr), .mem_resp_data_o(a_resp_data), .mem_resp_v_o(a_resp_v),
        .mem_resp_ready_and_i(a_resp_ready), .mem_resp_last_o(a_resp_last),
        .bank_cmd_header_o(a_bcmd_hdr), .bank_cmd_data_o(a_bcmd_data), .bank_cmd_v_o(a_bcmd_v),
        .bank_cmd_ready_and_i(a_bcmd_ready), .bank_cmd_last_o(a_bcmd_last),
        .bank_resp_header_i(a_bresp_hdr), .bank_resp_data_i(a_bresp_data), .bank_resp_v_i(a_bresp_v),
        .bank_resp_yumi_o(a_bresp_yumi), .bank_resp_last_i(a_bresp_last),
        .outstanding_o(a_outst)
    );

    bp_me_bank_dispatch #(
        .bp_params_p(e_bp_default_cfg), .data_width_p(64), .num_banks_p(2),
        .bank_offset_p(6), .hash_en_p(1), .max_outstanding_p(2)
    ) dut_b (
        .clk_i(clk), .reset_n_i(rst_n),
        .mem_cmd_header_i(b_cmd_hdr), .mem_cmd_data_i(b_cmd_data), .mem_cmd_v_i(b_cmd_v),
        .mem_cmd_ready_and_o(b_cmd_ready), .mem_cmd_last_i(b_cmd_last),
        .mem_resp_header_o(b_resp_hdr), .mem_resp_data_o(b_resp_data), .mem_resp_v_o(b_resp_v),
        .mem_resp_ready_and_i(b_resp_ready), .mem_resp_last_o(b_resp_last),
        .bank_cmd_header_o(b_bcmd_hdr), .bank_cmd_data_o(b_bcmd_data), .bank_cmd_v_o(b_bcmd_v),
        .bank_cmd_ready_and_i(b_bcmd_ready), .bank_cmd_last_o(b_bcmd_last),
        .bank_resp_header_i(b_bresp_hdr), .bank_resp_data_i(b_bresp_data), .bank_resp_v_i(b_bresp_v),
        .bank_resp_yumi_o(b_bresp_yumi), .bank_resp_last_i(b_bresp_last),
        .outstanding_o(b_outst)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bp_bedrock_mem_header_s mk_hdr(input logic [39:0] addr, input bp_bedrock_mem_type_e t);
        bp_bedrock_mem_header_s h;
        h          = '0;
        h.msg_type = t;
        h.addr     = {16'h0, addr};
        h.size     = e_bedrock_msg_size_64;
        return h;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  beats;
        logic bank1_rdy;

        rst_n        = 1'b0;
        a_cmd_hdr    = '0; a_cmd_data = '0; a_cmd_v = 1'b0; a_cmd_last = 1'b0; a_resp_ready = 1'b0;
        a_bcmd_ready = '0; a_bresp_hdr = '0; a_bresp_data = '0; a_bresp_v = '0; a_bresp_last = '0;
        b_cmd_hdr    = '0; b_cmd_data = '0; b_cmd_v = 1'b0; b_cmd_last = 1'b0; b_resp_ready = 1'b0;
        b_bcmd_ready = '0; b_bresp_hdr = '0; b_bresp_data = '0; b_bresp_v = '0; b_bresp_last = '0;

        // Reset state with live-looking inputs on every side
        a_bcmd_ready = 4'hF; a_cmd_v = 1'b1; a_cmd_last = 1'b1; a_cmd_hdr = mk_hdr(40'h0, e_bedrock_mem_rd);
        a_bresp_v    = 4'hF; a_bresp_last = 4'hF; a_resp_ready = 1'b1;
        #3;
        check("rst_cmd_ready", a_cmd_ready, 0);
        check("rst_bank_v",    a_bcmd_v, 0);
        check("rst_bank_last", a_bcmd_last, 0);
        check("rst_resp_v",    a_resp_v, 0);
        check("rst_resp_last", a_resp_last, 0);
        check("rst_yumi",      a_bresp_yumi, 0);
        check("rst_outst",     a_outst, 0);
        a_cmd_v = 1'b0; a_bresp_v = '0; a_bresp_last = '0;
        step(); step();
        rst_n = 1'b1;

        // Single-beat reads to 0x000/0x040/0x080/0x0C0 land on banks 0..3
        for (int i = 0; i < 4; i++) begin
            a_cmd_v = 1'b1; a_cmd_last = 1'b1; a_cmd_data = 64'(i);
            a_cmd_hdr = mk_hdr(40'(i) << 6, e_bedrock_mem_rd);
            #1;
            check("rd_outst",      a_outst, i);
            check("rd_bank_v",     a_bcmd_v, 4'b0001 << i);
            check("rd_ready",      a_cmd_ready, 1);
            check("rd_hdr_bcast",  a_bcmd_hdr[3].addr, 64'(i) << 6);
            step();
        end
        a_cmd_hdr = mk_hdr(40'h0, e_bedrock_mem_rd);
        #1;
        check("full_outst",  a_outst, 4);
        check("full_ready",  a_cmd_ready, 0);
        check("full_bank_v", a_bcmd_v, 0);
        a_cmd_v = 1'b0;

        // Bank 1 answers first and must wait behind bank 0
        a_bresp_data[0] = 64'hB0; a_bresp_data[1] = 64'hB1; a_bresp_last = 4'hF;
        a_bresp_hdr[0]  = mk_hdr(40'hABC, e_bedrock_mem_rd);
        a_bresp_v = 4'b0010; a_resp_ready = 1'b1;
        #1;
        check("ooo_resp_v_stall", a_resp_v, 0);
        check("ooo_yumi_stall",   a_bresp_yumi, 0);
        step();
        check("ooo_yumi_stall2",  a_bresp_yumi, 0);
        a_bresp_v = 4'b0011; a_resp_ready = 1'b0;
        #1;
        check("ooo_core_busy_v",    a_resp_v, 1);
        check("ooo_core_busy_yumi", a_bresp_yumi, 0);
        a_resp_ready = 1'b1;
        #1;
        check("ooo_b0_yumi", a_bresp_yumi, 4'b0001);
        check("ooo_b0_data", a_resp_data, 64'hB0);
        check("ooo_b0_hdr",  a_resp_hdr.addr, 64'hABC);
        check("ooo_b0_last", a_resp_last, 1);
        step();
        check("ooo_b1_data",  a_resp_data, 64'hB1);
        check("ooo_b1_yumi",  a_bresp_yumi, 4'b0010);
        check("ooo_outst3",   a_outst, 3);
        step();
        a_bresp_v = 4'b0100; a_bresp_last = 4'b0000; a_bresp_data[2] = 64'h20;
        #1;
        check("ooo_outst2",    a_outst, 2);
        check("b2_beat0_yumi", a_bresp_yumi, 4'b0100);
        check("b2_beat0_last", a_resp_last, 0);
        step();
        a_bresp_last = 4'b0100; a_bresp_data[2] = 64'h21;
        #1;
        check("b2_mid_outst",  a_outst, 2);
        check("b2_beat1_data", a_resp_data, 64'h21);
        check("b2_beat1_last", a_resp_last, 1);
        step();
        a_bresp_v = 4'b1000; a_bresp_last = 4'b1000; a_bresp_data[3] = 64'h33;
        #1;
        check("b3_outst", a_outst, 1);
        check("b3_data",  a_resp_data, 64'h33);
        step();
        a_bresp_v = '0; a_bresp_last = '0;
        #1;
        check("drain_outst",  a_outst, 0);
        check("drain_resp_v", a_resp_v, 0);

        // 8-beat write to 0x1040 while bank 1 toggles ready; later beats carry a bank-3 address
        beats = 0;
        for (int cyc = 0; cyc < 40 && beats < 8; cyc++) begin
            if (cyc != 0) step();
            bank1_rdy    = (cyc % 2 == 0);
            a_bcmd_ready = {1'b1, 1'b1, bank1_rdy, 1'b1};
            a_cmd_v      = 1'b1;
            a_cmd_hdr    = mk_hdr((beats == 0) ? 40'h1040 : 40'h00C0, e_bedrock_mem_wr);
            a_cmd_data   = 64'hD000 + 64'(beats);
            a_cmd_last   = (beats == 7);
            #1;
            check("wr_bank_v", a_bcmd_v, 4'b0010);
            check("wr_ready",  a_cmd_ready, bank1_rdy);
            if (bank1_rdy) begin
                check("wr_data", a_bcmd_data[1], 64'hD000 + 64'(beats));
                if (beats == 7) check("wr_last_bcast", a_bcmd_last, 4'hF);
                beats++;
            end
        end
        check("wr_beats", beats, 8);
        step();
        a_cmd_v = 1'b0; a_cmd_last = 1'b0; a_bcmd_ready = 4'hF;
        #1;
        check("wr_single_push", a_outst, 1);
        a_bresp_v = 4'b0010; a_bresp_last = 4'b0010;
        #1;
        check("wr_resp_yumi", a_bresp_yumi, 4'b0010);
        step();
        a_bresp_v = '0; a_bresp_last = '0;
        #1;
        check("wr_drained", a_outst, 0);

        // Reset in the middle of a 2-beat write to bank 2
        a_cmd_v = 1'b1; a_cmd_last = 1'b0; a_cmd_hdr = mk_hdr(40'h080, e_bedrock_mem_wr);
        #1;
        check("mid_first_bank_v", a_bcmd_v, 4'b0100);
        step();
        a_cmd_hdr = mk_hdr(40'h000, e_bedrock_mem_wr);
        #1;
        check("mid_stream_outst", a_outst, 1);
        check("mid_stream_route", a_bcmd_v, 4'b0100);
        a_cmd_last = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready",  a_cmd_ready, 0);
        check("mid_rst_bank_v", a_bcmd_v, 0);
        check("mid_rst_last",   a_bcmd_last, 0);
        check("mid_rst_outst",  a_outst, 0);
        step();
        rst_n = 1'b1;
        a_cmd_hdr = mk_hdr(40'h0C0, e_bedrock_mem_rd);
        #1;
        check("post_rst_bank_v", a_bcmd_v, 4'b1000);
        check("post_rst_ready",  a_cmd_ready, 1);
        step();
        a_cmd_v = 1'b0; a_cmd_last = 1'b0;
        #1;
        check("post_rst_outst", a_outst, 1);
        a_bresp_v = 4'b1000; a_bresp_last = 4'b1000;
        step();
        a_bresp_v = '0; a_bresp_last = '0;

        // Hashed 2-bank instance with a 2-deep order FIFO
        b_bcmd_ready = 2'b11; b_resp_ready = 1'b1; b_bresp_last = 2'b11;
        b_cmd_v = 1'b1; b_cmd_last = 1'b1; b_cmd_hdr = mk_hdr(40'h040, e_bedrock_mem_rd);
        #1;
        check("hash_040_bank_v", b_bcmd_v, 2'b10);
        check("hash_ready",      b_cmd_ready, 1);
        step();
        b_cmd_hdr = mk_hdr(40'h0C0, e_bedrock_mem_rd);
        #1;
        check("hash_0c0_bank_v", b_bcmd_v, 2'b01);
        check("b_outst1",        b_outst, 1);
        step();
        b_cmd_hdr = mk_hdr(40'h000, e_bedrock_mem_rd);
        b_bresp_v = 2'b10; b_bresp_data[1] = 64'h11;
        #1;
        check("b_full_outst",   b_outst, 2);
        check("b_full_ready",   b_cmd_ready, 0);
        check("b_full_bank_v",  b_bcmd_v, 0);
        check("b_full_pop_v",   b_resp_v, 1);
        check("b_full_pop_dat", b_resp_data, 64'h11);
        step();
        b_bresp_v = '0;
        #1;
        check("b_after_pop_outst",  b_outst, 1);
        check("b_after_pop_ready",  b_cmd_ready, 1);
        check("b_after_pop_bank_v", b_bcmd_v, 2'b01);
        step();
        b_cmd_v = 1'b0; b_bresp_v = 2'b01; b_bresp_data[0] = 64'h22;
        #1;
        check("b_outst2",  b_outst, 2);
        check("b_r0_data", b_resp_data, 64'h22);
        check("b_r0_yumi", b_bresp_yumi, 2'b01);
        step();
        b_cmd_v = 1'b1; b_cmd_hdr = mk_hdr(40'h040, e_bedrock_mem_rd); b_bresp_data[0] = 64'h33;
        #1;
        check("b_pp_outst",  b_outst, 1);
        check("b_pp_ready",  b_cmd_ready, 1);
        check("b_pp_bank_v", b_bcmd_v, 2'b10);
        check("b_pp_yumi",   b_bresp_yumi, 2'b01);
        step();
        b_cmd_v = 1'b0; b_bresp_v = 2'b11; b_bresp_data[1] = 64'h77;
        #1;
        check("b_pp_count_same", b_outst, 1);
        check("b_head1_data",    b_resp_data, 64'h77);
        check("b_head1_yumi",    b_bresp_yumi, 2'b10);
        step();
        b_bresp_v = '0;
        #1;
        check("b_empty_outst",  b_outst, 0);
        check("b_empty_resp_v", b_resp_v, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
